collision_score_engine: RTL and testbench
=========================================

Name: collision_score_engine

Overview:
- Parametrised successor to the per-level collision/score updater in the lane-crossing game.
- Each clock, checks the player hitbox against N_LANES moving bars and tracks progress and score.
- Adds a lives counter, a respawn hold, level-clear detection, game-over and a best-score register.
- Sits between the bar generators / player controller and the score display and VGA overlay.

Parameters:
COORD_W, 10, width of all coordinates, bar positions and bar lengths
N_LANES, 6, number of bar lanes
LANE_X0, 80, left x edge of lane 0
LANE_PITCH, 80, x distance between consecutive lane left edges
LANE_W, 80, x width of each lane
HALF_BOX, 20, player hitbox half-size (x and y)
HOLD_CYC, 2, cycles reset_player is held after reset or a hit
LIVES_INIT, 3, lives loaded at reset and at start
SCORE_W, 10, width of points and best

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; leaves GAME_OVER and begins a new game
bar_pos  in  N_LANES*COORD_W  top y of bar i at [i*COORD_W +: COORD_W]
bar_len  in  N_LANES*COORD_W  length of bar i, same packing
player_h  in  COORD_W  player centre x
player_v  in  COORD_W  player centre y
level  in  SCORE_W  current level, valid values 1 and up
points  out  SCORE_W  current score
best  out  SCORE_W  highest points value since reset
lives  out  4  remaining lives
reset_player  out  1  high while the player must be held at spawn
hit  out  1  one-cycle pulse on each collision
level_clear  out  1  one-cycle pulse when progress reaches N_LANES
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset is sampled only on the clk edge while reset==0, and overrides everything.
- Reset values: points=0, best=0, lives=LIVES_INIT, reset_player=1, hit=0, level_clear=0, game_over=0.
- After reset the block enters HOLD with hold_cnt=HOLD_CYC.
- All outputs are registered. Geometry arithmetic uses COORD_W+2 bits signed, so player_v-HALF_BOX near 0 never wraps.
- Lane i x-span: Lx_i = LANE_X0 + i*LANE_PITCH up to Lx_i+LANE_W.
- Lane i is active when (player_h+HALF_BOX > Lx_i) && (player_h-HALF_BOX < Lx_i+LANE_W). All comparisons are strict.
- Collision on lane i: lane i is active && (player_v+HALF_BOX > bar_pos_i) && (player_v-HALF_BOX < bar_pos_i+bar_len_i). All comparisons are strict.
- A bar with bar_len_i=0 never collides.
- progress = count of lanes with player_h >= Lx_i+LANE_W/2, range 0..N_LANES.
- points = (level-1)*N_LANES + progress, truncated to SCORE_W. level=0 is treated as 1.
- FSM states:
  - HOLD: reset_player=1; hold_cnt decrements each cycle; at hold_cnt==1 go to PLAY with reset_player=0 on the next edge. HOLD lasts exactly HOLD_CYC cycles. Inputs are ignored in HOLD.
  - PLAY: evaluate every cycle.
    - Any collision: next cycle hit=1, lives-=1, progress part of points=0, reset_player=1. If lives was 1, go to GAME_OVER; otherwise go to HOLD.
    - Else if progress==N_LANES: next cycle level_clear=1, reset_player=1, go to HOLD. points holds the final value for this level.
    - Else: update points.
    - Collision and progress==N_LANES in the same cycle: the collision wins, and there is no level_clear.
  - GAME_OVER: game_over=1, reset_player=1, points frozen, lives=0. A start pulse loads lives=LIVES_INIT and points=0, then goes to HOLD. start in any other state is ignored.
- best updates whenever points > best, in the same cycle points updates.
- Reset mid-HOLD or mid-PLAY restarts HOLD with all counters reinitialised. best is also cleared.

Test Plan:
- Reset low 3 cycles then high, no bars in range -> reset_player=1 for exactly 2 cycles after release, then 0; points=0; lives=3.
- PLAY, level=2, player_h=250 (progress=2), bars far away -> points=8 one cycle later; best=8.
- Lane 1 bar_pos=100, bar_len=60, player_h=170, player_v=150 -> hit pulses once; lives 3->2; reset_player=1 for 2 cycles; points progress part=0.
- Repeat collision 3 times -> third hit sets game_over=1, lives=0; start pulse -> lives=3, points=0, HOLD, then PLAY.
- player_h=600 with no collision -> level_clear single pulse, points=(level-1)*6+6; same with a simultaneous lane-5 collision -> hit only, no level_clear.
- player_v=5 and bar_pos=0, bar_len=10 on an active lane -> collision detected, with no wrap artefact; bar_len=0 at the same position -> no hit.

Source files
------------

// File: rtl/collision_score_if.sv
// Bundle of game-state inputs from the bar generators / player controller
// and the score/status outputs toward the display and overlay.
interface collision_score_if #(
  parameter int COORD_W = 10,
  parameter int N_LANES = 6,
  parameter int SCORE_W = 10
);
  logic                         start;
  logic [N_LANES*COORD_W-1:0]   bar_pos;
  logic [N_LANES*COORD_W-1:0]   bar_len;
  logic [COORD_W-1:0]           player_h;
  logic [COORD_W-1:0]           player_v;
  logic [SCORE_W-1:0]           level;
  logic [SCORE_W-1:0]           points;
  logic [SCORE_W-1:0]           best;
  logic [3:0]                   lives;
  logic                         reset_player;
  logic                         hit;
  logic                         level_clear;
  logic                         game_over;

  modport master (
    output start, bar_pos, bar_len, player_h, player_v, level,
    input  points, best, lives, reset_player, hit, level_clear, game_over
  );

  modport slave (
    input  start, bar_pos, bar_len, player_h, player_v, level,
    output points, best, lives, reset_player, hit, level_clear, game_over
  );
endinterface

// File: rtl/collision_score_engine.sv
// Per-cycle player/bar collision check with progress, score, lives,
// respawn hold, level-clear, game-over and best-score tracking.
module collision_score_engine #(
  parameter int COORD_W    = 10,
  parameter int N_LANES    = 6,
  parameter int LANE_X0    = 80,
  parameter int LANE_PITCH = 80,
  parameter int LANE_W     = 80,
  parameter int HALF_BOX   = 20,
  parameter int HOLD_CYC   = 2,
  parameter int LIVES_INIT = 3,
  parameter int SCORE_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  collision_score_if.slave  bus
);

  localparam int GW   = COORD_W + 2;
  localparam int PW   = $clog2(N_LANES + 1);
  localparam int HC_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

  localparam logic signed [GW-1:0] HALF_S   = GW'(HALF_BOX);
  localparam logic signed [GW-1:0] LANE_W_S = GW'(LANE_W);
  localparam logic signed [GW-1:0] MID_S    = GW'(LANE_W / 2);
  localparam logic [HC_W-1:0]      HOLD_INIT = HC_W'(HOLD_CYC);
  localparam logic [3:0]           LIVES_RST = 4'(LIVES_INIT);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t              state_r, state_n;
  logic [HC_W-1:0]     hold_cnt_r, hold_cnt_n;
  logic [SCORE_W-1:0]  points_r, points_n;
  logic [SCORE_W-1:0]  best_r, best_n;
  logic [3:0]          lives_r, lives_n;
  logic                reset_player_r, reset_player_n;
  logic                hit_r, hit_n;
  logic                level_clear_r, level_clear_n;
  logic                game_over_r, game_over_n;

  logic signed [GW-1:0] ph_s, pv_s;
  logic [N_LANES-1:0]   lane_active_s, lane_hit_s, lane_passed_s;
  logic [PW-1:0]        progress_s;
  logic [SCORE_W-1:0]   level_eff_s, base_s, play_pts_s, clear_pts_s;
  logic                 any_hit_s, all_clear_s;

  // Two extra bits keep player_v-HALF_BOX negative instead of wrapping near 0.
  assign ph_s = $signed({2'b00, bus.player_h});
  assign pv_s = $signed({2'b00, bus.player_v});

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    localparam logic signed [GW-1:0] LX_S = GW'(LANE_X0 + i * LANE_PITCH);
    logic signed [GW-1:0] bp_s, bl_s;
    assign bp_s = $signed({2'b00, bus.bar_pos[i*COORD_W +: COORD_W]});
    assign bl_s = $signed({2'b00, bus.bar_len[i*COORD_W +: COORD_W]});
    assign lane_active_s[i] = (ph_s + HALF_S > LX_S) && (ph_s - HALF_S < LX_S + LANE_W_S);
    assign lane_hit_s[i]    = lane_active_s[i] && (bl_s != '0) &&
                              (pv_s + HALF_S > bp_s) && (pv_s - HALF_S < bp_s + bl_s);
    assign lane_passed_s[i] = (ph_s >= LX_S + MID_S);
  end

  // Count lanes whose midpoint the player has reached.
  always_comb begin
    progress_s = '0;
    for (int i = 0; i < N_LANES; i++) begin
      progress_s = progress_s + PW'(lane_passed_s[i]);
    end
  end

  assign any_hit_s   = |lane_hit_s;
  assign all_clear_s = (progress_s == PW'(N_LANES));
  assign level_eff_s = (bus.level == '0) ? SCORE_W'(1) : bus.level;
  assign base_s      = (level_eff_s - SCORE_W'(1)) * SCORE_W'(N_LANES);
  assign play_pts_s  = base_s + SCORE_W'(progress_s);
  assign clear_pts_s = base_s + SCORE_W'(N_LANES);

  // Next-state and next-output logic for the HOLD/PLAY/GAME_OVER machine.
  always_comb begin
    state_n        = state_r;
    hold_cnt_n     = hold_cnt_r;
    points_n       = points_r;
    lives_n        = lives_r;
    reset_player_n = reset_player_r;
    hit_n          = 1'b0;
    level_clear_n  = 1'b0;
    game_over_n    = game_over_r;
    case (state_r)
      ST_HOLD: begin
        reset_player_n = 1'b1;
        game_over_n    = 1'b0;
        if (hold_cnt_r <= HC_W'(1)) begin
          state_n        = ST_PLAY;
          hold_cnt_n     = '0;
          reset_player_n = 1'b0;
        end else begin
          hold_cnt_n = hold_cnt_r - HC_W'(1);
        end
      end
      ST_PLAY: begin
        reset_player_n = 1'b0;
        game_over_n    = 1'b0;
        if (any_hit_s) begin
          // A collision beats a simultaneous level clear.
          hit_n          = 1'b1;
          points_n       = base_s;
          reset_player_n = 1'b1;
          if (lives_r <= 4'd1) begin
            state_n     = ST_OVER;
            lives_n     = 4'd0;
            game_over_n = 1'b1;
          end else begin
            state_n    = ST_HOLD;
            lives_n    = lives_r - 4'd1;
            hold_cnt_n = HOLD_INIT;
          end
        end else if (all_clear_s) begin
          level_clear_n  = 1'b1;
          points_n       = clear_pts_s;
          reset_player_n = 1'b1;
          state_n        = ST_HOLD;
          hold_cnt_n     = HOLD_INIT;
        end else begin
          points_n = play_pts_s;
        end
      end
      ST_OVER: begin
        reset_player_n = 1'b1;
        if (bus.start) begin
          state_n     = ST_HOLD;
          hold_cnt_n  = HOLD_INIT;
          lives_n     = LIVES_RST;
          points_n    = '0;
          game_over_n = 1'b0;
        end else begin
          state_n     = ST_OVER;
          lives_n     = 4'd0;
          game_over_n = 1'b1;
        end
      end
      default: begin
        state_n        = ST_HOLD;
        hold_cnt_n     = HOLD_INIT;
        reset_player_n = 1'b1;
        game_over_n    = 1'b0;
      end
    endcase
    best_n = (points_n > best_r) ? points_n : best_r;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r        <= ST_HOLD;
      hold_cnt_r     <= HOLD_INIT;
      points_r       <= '0;
      best_r         <= '0;
      lives_r        <= LIVES_RST;
      reset_player_r <= 1'b1;
      hit_r          <= 1'b0;
      level_clear_r  <= 1'b0;
      game_over_r    <= 1'b0;
    end else begin
      state_r        <= state_n;
      hold_cnt_r     <= hold_cnt_n;
      points_r       <= points_n;
      best_r         <= best_n;
      lives_r        <= lives_n;
      reset_player_r <= reset_player_n;
      hit_r          <= hit_n;
      level_clear_r  <= level_clear_n;
      game_over_r    <= game_over_n;
    end
  end

  assign bus.points       = points_r;
  assign bus.best         = best_r;
  assign bus.lives        = lives_r;
  assign bus.reset_player = reset_player_r;
  assign bus.hit          = hit_r;
  assign bus.level_clear  = level_clear_r;
  assign bus.game_over    = game_over_r;

endmodule

// File: tb/tb_collision_score_engine.sv
// Directed bench for collision_score_engine: inputs change on the falling
// edge, registered outputs are compared on the following falling edge.
module tb_collision_score_engine;
  localparam int COORD_W = 10;
  localparam int N_LANES = 6;
  localparam int SCORE_W = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  collision_score_if #(.COORD_W(COORD_W), .N_LANES(N_LANES), .SCORE_W(SCORE_W)) bus ();

  collision_score_engine #(.COORD_W(COORD_W), .N_LANES(N_LANES), .SCORE_W(SCORE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bars parked at y=1000, player at top-left of the field, no start.
  task automatic safe_inputs();
    for (int i = 0; i < N_LANES; i++) begin
      bus.bar_pos[i*COORD_W +: COORD_W] = 10'd1000;
      bus.bar_len[i*COORD_W +: COORD_W] = 10'd10;
    end
    bus.player_h = 10'd40;
    bus.player_v = 10'd300;
    bus.start    = 1'b0;
  endtask

  task automatic set_bar(input int lane, input logic [9:0] pos, input logic [9:0] len);
    bus.bar_pos[lane*COORD_W +: COORD_W] = pos;
    bus.bar_len[lane*COORD_W +: COORD_W] = len;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.level = 10'd1;
    safe_inputs();
    repeat (3) tick();
    checks++; if (bus.reset_player !== 1'b1) begin errors++; $display("FAIL rst_rp: got %b exp 1", bus.reset_player); end
    checks++; if (bus.points !== 10'd0) begin errors++; $display("FAIL rst_points: got %0d exp 0", bus.points); end
    checks++; if (bus.best !== 10'd0) begin errors++; $display("FAIL rst_best: got %0d exp 0", bus.best); end
    checks++; if (bus.lives !== 4'd3) begin errors++; $display("FAIL rst_lives: got %0d exp 3", bus.lives); end
    checks++; if ({bus.hit, bus.level_clear, bus.game_over} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b exp 000", {bus.hit, bus.level_clear, bus.game_over}); end
    reset = 1'b1;
    tick();
    checks++; if (bus.reset_player !== 1'b1) begin errors++; $display("FAIL hold_c1_rp: got %b exp 1", bus.reset_player); end
    tick();
    checks++; if (bus.reset_player !== 1'b0) begin errors++; $display("FAIL hold_end_rp: got %b exp 0", bus.reset_player); end
    tick();
    checks++; if (bus.points !== 10'd0 || bus.lives !== 4'd3) begin errors++; $display("FAIL play_idle: got pts %0d lives %0d exp 0 3", bus.points, bus.lives); end
  endtask

  task automatic test_points();
    bus.level = 10'd2;
    bus.player_h = 10'd250;
    tick();
    checks++; if (bus.points !== 10'd8) begin errors++; $display("FAIL pts_l2: got %0d exp 8", bus.points); end
    checks++; if (bus.best !== 10'd8) begin errors++; $display("FAIL best_l2: got %0d exp 8", bus.best); end
    bus.level = 10'd0;
    bus.player_h = 10'd40;
    tick();
    checks++; if (bus.points !== 10'd0) begin errors++; $display("FAIL pts_l0: got %0d exp 0", bus.points); end
    checks++; if (bus.best !== 10'd8) begin errors++; $display("FAIL best_keep: got %0d exp 8", bus.best); end
  endtask

  task automatic test_hit();
    bus.level = 10'd1;
    bus.player_h = 10'd170;
    bus.player_v = 10'd150;
    set_bar(1, 10'd100, 10'd60);
    tick();
    checks++; if (bus.hit !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %b exp 1", bus.hit); end
    checks++; if (bus.lives !== 4'd2) begin errors++; $display("FAIL hit_lives: got %0d exp 2", bus.lives); end
    checks++; if (bus.points !== 10'd0 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL hit_pts_rp: got %0d %b exp 0 1", bus.points, bus.reset_player); end
    safe_inputs();
    tick();
    checks++; if (bus.hit !== 1'b0 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL hit_after: got hit %b rp %b exp 0 1", bus.hit, bus.reset_player); end
    tick();
    checks++; if (bus.reset_player !== 1'b0) begin errors++; $display("FAIL hit_respawn: got %b exp 0", bus.reset_player); end
  endtask

  task automatic test_game_over();
    bus.player_h = 10'd170;
    bus.player_v = 10'd150;
    set_bar(1, 10'd100, 10'd60);
    tick();
    checks++; if (bus.hit !== 1'b1 || bus.lives !== 4'd1) begin errors++; $display("FAIL go_hit2: got hit %b lives %0d exp 1 1", bus.hit, bus.lives); end
    safe_inputs();
    repeat (2) tick();
    bus.player_h = 10'd170;
    bus.player_v = 10'd150;
    set_bar(1, 10'd100, 10'd60);
    tick();
    checks++; if (bus.game_over !== 1'b1 || bus.lives !== 4'd0 || bus.hit !== 1'b1) begin errors++; $display("FAIL go_enter: got go %b lives %0d hit %b exp 1 0 1", bus.game_over, bus.lives, bus.hit); end
    repeat (2) tick();
    checks++; if (bus.game_over !== 1'b1 || bus.hit !== 1'b0 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL go_stay: got go %b hit %b rp %b exp 1 0 1", bus.game_over, bus.hit, bus.reset_player); end
    bus.start = 1'b1;
    tick();
    safe_inputs();
    checks++; if (bus.lives !== 4'd3 || bus.points !== 10'd0 || bus.game_over !== 1'b0) begin errors++; $display("FAIL go_start: got lives %0d pts %0d go %b exp 3 0 0", bus.lives, bus.points, bus.game_over); end
    checks++; if (bus.reset_player !== 1'b1) begin errors++; $display("FAIL go_start_rp: got %b exp 1", bus.reset_player); end
    repeat (2) tick();
    checks++; if (bus.reset_player !== 1'b0) begin errors++; $display("FAIL go_replay: got %b exp 0", bus.reset_player); end
  endtask

  task automatic test_start_ignored();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.lives !== 4'd3 || bus.game_over !== 1'b0 || bus.reset_player !== 1'b0) begin errors++; $display("FAIL start_ign: got lives %0d go %b rp %b exp 3 0 0", bus.lives, bus.game_over, bus.reset_player); end
  endtask

  task automatic test_level_clear();
    bus.level = 10'd3;
    bus.player_h = 10'd600;
    tick();
    checks++; if (bus.level_clear !== 1'b1 || bus.hit !== 1'b0) begin errors++; $display("FAIL lc_pulse: got lc %b hit %b exp 1 0", bus.level_clear, bus.hit); end
    checks++; if (bus.points !== 10'd18 || bus.best !== 10'd18) begin errors++; $display("FAIL lc_pts: got %0d best %0d exp 18 18", bus.points, bus.best); end
    safe_inputs();
    tick();
    checks++; if (bus.level_clear !== 1'b0 || bus.points !== 10'd18) begin errors++; $display("FAIL lc_single: got lc %b pts %0d exp 0 18", bus.level_clear, bus.points); end
    repeat (2) tick();
    checks++; if (bus.points !== 10'd12) begin errors++; $display("FAIL lc_next: got %0d exp 12", bus.points); end
    bus.player_h = 10'd530;
    bus.player_v = 10'd150;
    set_bar(5, 10'd100, 10'd60);
    tick();
    checks++; if (bus.hit !== 1'b1 || bus.level_clear !== 1'b0) begin errors++; $display("FAIL lc_vs_hit: got hit %b lc %b exp 1 0", bus.hit, bus.level_clear); end
    checks++; if (bus.lives !== 4'd2 || bus.points !== 10'd12) begin errors++; $display("FAIL lc_hit_state: got lives %0d pts %0d exp 2 12", bus.lives, bus.points); end
    safe_inputs();
    repeat (2) tick();
  endtask

  task automatic test_wrap();
    bus.level = 10'd1;
    bus.player_h = 10'd170;
    bus.player_v = 10'd5;
    set_bar(1, 10'd0, 10'd10);
    tick();
    checks++; if (bus.hit !== 1'b1 || bus.lives !== 4'd1) begin errors++; $display("FAIL wrap_hit: got hit %b lives %0d exp 1 1", bus.hit, bus.lives); end
    safe_inputs();
    repeat (2) tick();
    bus.player_h = 10'd170;
    bus.player_v = 10'd5;
    set_bar(1, 10'd0, 10'd0);
    tick();
    checks++; if (bus.hit !== 1'b0 || bus.points !== 10'd1) begin errors++; $display("FAIL len0: got hit %b pts %0d exp 0 1", bus.hit, bus.points); end
    bus.player_v = 10'd80;
    set_bar(1, 10'd100, 10'd10);
    tick();
    checks++; if (bus.hit !== 1'b0 || bus.lives !== 4'd1) begin errors++; $display("FAIL touch_edge: got hit %b lives %0d exp 0 1", bus.hit, bus.lives); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    tick();
    checks++; if (bus.best !== 10'd0 || bus.points !== 10'd0 || bus.lives !== 4'd3 || bus.reset_player !== 1'b1) begin errors++; $display("FAIL mid_reset: got best %0d pts %0d lives %0d rp %b exp 0 0 3 1", bus.best, bus.points, bus.lives, bus.reset_player); end
    reset = 1'b1;
    safe_inputs();
    tick();
    checks++; if (bus.reset_player !== 1'b1) begin errors++; $display("FAIL mid_hold: got %b exp 1", bus.reset_player); end
  endtask

  initial begin
    reset = 1'b0;
    safe_inputs();
    bus.level = 10'd1;
    @(negedge clk);
    test_reset();
    test_points();
    test_hit();
    test_game_over();
    test_start_ignored();
    test_level_clear();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
